ctrl_int: RTL and testbench
===========================

Name: ctrl_int

Overview:
- Interrupt controller for the CPU.
- Collects request lines from the I/O block (one per input port e1..e4).
- Latches rising edges as pending interrupts, applies a software mask, and presents one request at a time to the control unit (uc) together with a program-memory vector address.
- Sequences the accept/service/end-of-interrupt handshake; no nesting.

Parameters:
- ADDR_W, 10, width of the program-memory address carried on vector.
- VEC_BASE, 10'h3F0, address of the source-0 handler; source i handler = VEC_BASE + i.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- irq  in  4  request lines from e_s, level; bit i = port e(i+1).
- we_mask  in  1  mask write strobe from the datapath.
- mask_in  in  4  new mask value; a 1 disables that source.
- int_ack  in  1  uc accepts the request; 1-cycle pulse.
- int_eoi  in  1  uc signals end of handler; 1-cycle pulse.
- int_req  out  1  interrupt request to uc.
- vector  out  ADDR_W  handler address; valid while int_req=1.
- pending  out  4  pending-interrupt register, for debug/readback.
- mask  out  4  current mask register.
- in_service  out  1  1 while a handler is executing.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high.
  - Every register updates only on the rising clk edge.
- Reset values (reset=1 at a clk edge):
  - int_req=0, vector=0, pending=0, mask=4'b1111 (all sources disabled), in_service=0, state=IDLE.
  - Edge register irq_q loads irq, so levels held through reset do not create an edge.
- Edge detection:
  - rise = irq & ~irq_q; irq_q <= irq every cycle.
  - pending[i] is set when rise[i]=1.
  - pending[i] is cleared only when source i is acknowledged.
  - If set and clear fall on the same cycle and the same bit, set wins.
- Mask:
  - On we_mask=1, mask <= mask_in at the next edge.
  - Masking never clears pending; it only blocks selection.
- eligible = pending & ~mask.
- State machine:
  - IDLE:
    - If eligible != 0, select the winner; fixed priority, bit 0 highest.
    - Register sel <= winner, vector <= VEC_BASE + sel, int_req <= 1, go to REQ.
    - int_eoi and int_ack are ignored.
  - REQ:
    - Hold int_req=1 and vector stable.
    - A mask write or a new edge does not change the selection.
    - On int_ack=1: pending[sel] <= 0, int_req <= 0, in_service <= 1, go to SERV.
    - int_eoi is ignored.
  - SERV:
    - On int_eoi=1: in_service <= 0, go to IDLE.
    - int_ack is ignored.
    - New edges keep accumulating in pending.
    - vector holds its last value.
- Latency:
  - irq rises before edge k: pending[i]=1 after k, int_req=1 after k+1.
  - After int_eoi at edge m, the next eligible request gives int_req=1 after m+1.
- Edge cases:
  - Multiple simultaneous edges: all are latched and served one per handshake, in priority order.
  - Repeated edges on an already pending source collapse into one pending bit.
  - irq held high produces no further requests until it goes low and then high again.
  - Reset mid-handshake (REQ or SERV) aborts immediately; all registers return to reset values.

Optional Feature:
- Macro CTRL_INT_ROUND_ROBIN_EN.
- When defined:
  - Selection in IDLE is round-robin.
  - The search starts at (last_served+1) mod 4 and wraps.
  - last_served is a 2-bit register, updated on int_ack, reset to 3 (so the first search starts at bit 0).
- When undefined: fixed priority, bit 0 highest, and no last_served register.
- Handshake, latency and port list are identical in both builds.

Test Plan:
- Reset defaults:
  - Hold reset 2 cycles with irq=4'b0100.
  - Expect int_req=0, pending=0, mask=4'hF, in_service=0.
  - Release reset with irq still high: pending stays 0.
- Single request:
  - Write mask=4'b0000, then raise irq[2] before edge k.
  - Expect pending=4'b0100 after k; int_req=1 and vector=10'h3F2 after k+1.
  - Pulse int_ack: pending=0, in_service=1.
  - Pulse int_eoi: in_service=0, state back to IDLE.
- Priority:
  - With mask=0, raise irq[3] and irq[1] on the same cycle.
  - Expect vector=10'h3F1 first.
  - After ack/eoi, expect vector=10'h3F3; two requests total.
- Masking:
  - Set mask=4'b0001 and raise irq[0].
  - Expect pending=4'b0001 and int_req=0.
  - Write mask=0: int_req=1 two cycles later, vector=10'h3F0.
- Edge cases:
  - Re-raise irq[1] on the cycle its int_ack is given: pending[1] stays 1.
  - Assert reset while in SERV: in_service=0, pending=0 on the next edge.
- ROUND_ROBIN build:
  - Keep irq[0] and irq[1] retriggering (pulse low/high between services).
  - Expect vectors alternating 3F0, 3F1, 3F0, 3F1.
  - In the fixed-priority build, expect 3F0 every time.

Source files
------------

// File: rtl/ctrl_int.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_int
// Description : Interrupt controller for the CPU. Rising edges on the four
//               I/O request lines are latched as pending interrupts. A software
//               mask blocks selection. One request at a time is presented to
//               the control unit (uc) with a handler vector address, and the
//               accept / service / end-of-interrupt handshake is sequenced.
//               Interrupts do not nest.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional    : CTRL_INT_ROUND_ROBIN_EN
//               When defined, the source is chosen by round-robin starting after
//               the last acknowledged source.
//               When undefined, the choice is fixed priority with bit 0 highest.
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1       system clock, rising edge
//   reset      in   1       synchronous active-high reset
//   irq        in   4       request levels, bit i = port e(i+1)
//   we_mask    in   1       mask write strobe
//   mask_in    in   4       new mask value (1 = source disabled)
//   int_ack    in   1       uc accepts the presented request (pulse)
//   int_eoi    in   1       uc signals end of handler (pulse)
//   int_req    out  1       interrupt request to uc
//   vector     out  ADDR_W  handler address, valid while int_req=1
//   pending    out  4       pending-interrupt register
//   mask       out  4       current mask register
//   in_service out  1       handler currently executing
// ============================================================================
module ctrl_int #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] VEC_BASE = 10'h3F0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        irq,
  input  logic              we_mask,
  input  logic [3:0]        mask_in,
  input  logic              int_ack,
  input  logic              int_eoi,
  output logic              int_req,
  output logic [ADDR_W-1:0] vector,
  output logic [3:0]        pending,
  output logic [3:0]        mask,
  output logic              in_service
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SERV = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        irq_q;
  logic [3:0]        pending_q, pending_d;
  logic [3:0]        mask_q, mask_d;
  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] vector_q, vector_d;
  logic              int_req_q, int_req_d;
  logic              in_service_q, in_service_d;

  logic [3:0]        rise;
  logic [3:0]        eligible;
  logic [3:0]        clr;
  logic [1:0]        win;
  logic              win_valid;
  logic              take;

  assign rise      = irq & ~irq_q;
  assign eligible  = pending_q & ~mask_q;
  assign win_valid = |eligible;
  assign take      = (state_q == S_REQ) && int_ack;
  // Only the acknowledged source is cleared; a new edge in that same cycle is
  // OR-ed back in afterwards so the set takes precedence.
  assign clr       = take ? (4'b0001 << sel_q) : 4'b0000;

`ifdef CTRL_INT_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;
  logic [1:0] rr_idx;
  logic       rr_found;

  // Search starts one past the last served source and wraps modulo 4.
  always_comb begin
    win      = 2'd0;
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rr_idx = last_q + 2'(k + 1);
      if (!rr_found && eligible[rr_idx]) begin
        win      = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (take) begin
      last_d = sel_q;
    end
  end

  // Reset to 3 so that the first search begins at source 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 2'd3;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: scan from the top down so the lowest index wins.
  always_comb begin
    win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (eligible[k]) begin
        win = 2'(k);
      end
    end
  end
`endif

  // State register and all other storage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      irq_q        <= irq;  // levels held through reset do not create an edge
      pending_q    <= 4'b0000;
      mask_q       <= 4'b1111;
      sel_q        <= 2'd0;
      vector_q     <= '0;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      sel_q        <= sel_d;
      vector_q     <= vector_d;
      int_req_q    <= int_req_d;
      in_service_q <= in_service_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_valid) state_d = S_REQ;
      S_REQ:   if (int_ack)   state_d = S_SERV;
      S_SERV:  if (int_eoi)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    pending_d    = (pending_q & ~clr) | rise;
    mask_d       = we_mask ? mask_in : mask_q;
    sel_d        = sel_q;
    vector_d     = vector_q;
    int_req_d    = int_req_q;
    in_service_d = in_service_q;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          sel_d     = win;
          vector_d  = VEC_BASE + ADDR_W'(win);
          int_req_d = 1'b1;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
        end
      end
      S_SERV: begin
        if (int_eoi) begin
          in_service_d = 1'b0;
        end
      end
      default: begin
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  assign int_req    = int_req_q;
  assign vector     = vector_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign in_service = in_service_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_int.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_int
// Description : Self-checking bench for ctrl_int. A table of per-cycle input
//               and expected-output records covers reset, the single request,
//               priority, masking, set-wins-over-clear and reset while in
//               service. A hand-written retrigger sequence then checks the
//               order in which vectors are served.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_int;

`ifdef CTRL_INT_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       we_mask;
  logic [3:0] mask_in;
  logic       int_ack;
  logic       int_eoi;
  logic       int_req;
  logic [9:0] vector;
  logic [3:0] pending;
  logic [3:0] mask;
  logic       in_service;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctrl_int #(.ADDR_W(10), .VEC_BASE(10'h3F0)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .we_mask    (we_mask),
    .mask_in    (mask_in),
    .int_ack    (int_ack),
    .int_eoi    (int_eoi),
    .int_req    (int_req),
    .vector     (vector),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service)
  );

  typedef struct {
    logic       rst;
    logic [3:0] irq;
    logic       we;
    logic [3:0] mi;
    logic       ack;
    logic       eoi;
    logic       req;
    logic [9:0] vec;
    logic [3:0] pend;
    logic [3:0] msk;
    logic       srv;
  } vec_t;

  vec_t       tbl[$];
  vec_t       sb[$];
  logic [9:0] vsb[$];

  function automatic vec_t mk(logic rst, logic [3:0] i, logic we, logic [3:0] mi,
                              logic ack, logic eoi, logic req, logic [9:0] vec,
                              logic [3:0] pend, logic [3:0] msk, logic srv);
    vec_t r;
    r.rst = rst; r.irq = i; r.we = we; r.mi = mi; r.ack = ack; r.eoi = eoi;
    r.req = req; r.vec = vec; r.pend = pend; r.msk = msk; r.srv = srv;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] v1, v2, ev;
    logic [3:0] p1;
    vec_t e;
    bit   seen;

    reset = 1'b1; irq = 4'b0; we_mask = 1'b0; mask_in = 4'b0;
    int_ack = 1'b0; int_eoi = 1'b0;

    // Round-robin changes only the order of the two-source priority case.
    v1 = RR ? 10'h3F3 : 10'h3F1;
    p1 = RR ? 4'b0010 : 4'b1000;
    v2 = RR ? 10'h3F1 : 10'h3F3;

    //                  rst irq     we mi      ack eoi | req vec      pend     msk      srv
    tbl.push_back(mk(1, 4'b0100, 0, 4'b0000, 0, 0,   0, 10'h000, 4'b0000, 4'b1111, 0));
    tbl.push_back(mk(1, 4'b0100, 0, 4'b0000, 0, 0,   0, 10'h000, 4'b0000, 4'b1111, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0000, 0, 0,   0, 10'h000, 4'b0000, 4'b1111, 0));
    tbl.push_back(mk(0, 4'b0100, 1, 4'b0000, 0, 0,   0, 10'h000, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 10'h000, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0000, 0, 0,   0, 10'h000, 4'b0100, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0000, 0, 0,   1, 10'h3F2, 4'b0100, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0000, 1, 0,   0, 10'h3F2, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 10'h3F2, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 10'h3F2, 4'b0000, 4'b0000, 0));
    // two simultaneous edges
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0000, 0, 0,   0, 10'h3F2, 4'b1010, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0000, 0, 0,   1, v1,      4'b1010, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0000, 1, 0,   0, v1,      p1,      4'b0000, 1));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0000, 0, 1,   0, v1,      p1,      4'b0000, 0));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0000, 0, 0,   1, v2,      p1,      4'b0000, 0));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0000, 1, 0,   0, v2,      4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0000, 0, 1,   0, v2,      4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0,   0, v2,      4'b0000, 4'b0000, 0));
    // masking
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0001, 0, 0,   0, v2,      4'b0000, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0,   0, v2,      4'b0001, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0,   0, v2,      4'b0001, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b0001, 1, 4'b0000, 0, 0,   0, v2,      4'b0001, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0,   1, 10'h3F0, 4'b0001, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 10'h3F0, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 10'h3F0, 4'b0000, 4'b0000, 0));
    // new edge on the acknowledge cycle: set beats clear
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 0,   0, 10'h3F0, 4'b0010, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 10'h3F1, 4'b0010, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 1, 0,   0, 10'h3F1, 4'b0010, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 1,   0, 10'h3F1, 4'b0010, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 0, 0,   1, 10'h3F1, 4'b0010, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 10'h3F1, 4'b0000, 4'b0000, 1));
    // reset while in service
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0,   0, 10'h000, 4'b0000, 4'b1111, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 10'h000, 4'b0000, 4'b1111, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset   = tbl[i].rst;
      irq     = tbl[i].irq;
      we_mask = tbl[i].we;
      mask_in = tbl[i].mi;
      int_ack = tbl[i].ack;
      int_eoi = tbl[i].eoi;
      sb.push_back(tbl[i]);
      tick();
      e = sb.pop_front();
      chk("int_req",    i, 32'(int_req),    32'(e.req));
      chk("vector",     i, 32'(vector),     32'(e.vec));
      chk("pending",    i, 32'(pending),    32'(e.pend));
      chk("mask",       i, 32'(mask),       32'(e.msk));
      chk("in_service", i, 32'(in_service), 32'(e.srv));
    end

    // Retrigger sources 0 and 1 between services and record the serve order.
    reset = 1'b1; irq = 4'b0000; we_mask = 1'b0; int_ack = 1'b0; int_eoi = 1'b0;
    tick();
    tick();
    reset = 1'b0; we_mask = 1'b1; mask_in = 4'b0000;
    tick();
    we_mask = 1'b0;
    irq = 4'b0011;
    for (int n = 0; n < 4; n++) begin
      vsb.push_back((RR && (n % 2 == 1)) ? 10'h3F1 : 10'h3F0);
    end
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick();
        seen = int_req;
      end
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL rr_timeout svc=%0d got=int_req 0 want=int_req 1", n);
      end else begin
        ev = vsb.pop_front();
        chk("rr_vector", n, 32'(vector), 32'(ev));
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("rr_in_service", n, 32'(in_service), 32'd1);
        irq = 4'b0000;
        tick();
        irq = 4'b0011;
        tick();
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
